// File: rtl/alu_commit_pkg.sv
// Shared encodings for the ALU commit stage: effect codes, flag layout, store-condition helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_commit_pkg;

    // Effect code carried alongside each ALU result.
    typedef enum logic [2:0] {
        EFF_IF_Z       = 3'd0,  // store if zero
        EFF_IF_NZ      = 3'd1,  // store if not zero
        EFF_IF_N       = 3'd2,  // store if negative
        EFF_IF_POS     = 3'd3,  // store if strictly positive (~N & ~Z)
        EFF_ALWAYS     = 3'd4,  // store unconditionally
        EFF_FLAGS_ONLY = 3'd5,  // update flags, never store
        EFF_NEVER      = 3'd6,  // no store, no flag update
        EFF_RESERVED   = 3'd7   // behaves as EFF_NEVER
    } effect_t;

    // Architectural flag word layout; sign copy lives in the upper field.
    typedef struct packed {
        logic [6:0] hi;     // bits 15:9
        logic       sign;   // bit 8
        logic [2:0] mid;    // bits 7:5
        logic       de;     // bit 4, divide error
        logic       o;      // bit 3, overflow
        logic       c;      // bit 2, carry
        logic       n;      // bit 1, negative
        logic       z;      // bit 0, zero
    } flags_t;

    // Effects 6 and 7 suppress everything: store, flag update and trap.
    function automatic logic effect_is_dead(input effect_t eff);
        return (eff == EFF_NEVER) || (eff == EFF_RESERVED);
    endfunction

    // Whether the op's own flags satisfy the effect's store condition.
    function automatic logic store_cond(input effect_t eff, input logic z, input logic n);
        logic hit;
        hit = 1'b0;
        case (eff)
            EFF_IF_Z:   hit = z;
            EFF_IF_NZ:  hit = ~z;
            EFF_IF_N:   hit = n;
            EFF_IF_POS: hit = ~n & ~z;
            EFF_ALWAYS: hit = 1'b1;
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/alu_commit_wb_fifo.sv
// Small valid/ready FIFO holding {tag,result} entries bound for register-file writeback.
// Latency: 1 cycle push-to-head; no same-cycle bypass when full.
// Backpressure: push ignored when count==DEPTH; head and data held while out_valid & ~out_ready.
//
// Ports: clock/reset (async, active-high); in_valid/in_data push side;
//        out_valid/out_ready/out_data pop side (data reads 0 when empty); count = occupancy.
module alu_commit_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 20
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign push      = in_valid & (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // Zero the head when empty so downstream never sees stale entries.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_commit.sv
// ALU commit stage: store/skip decision, architectural flags register, sticky divide trap, writeback queue.
// Latency: flags and wb head update 1 cycle after accept.
// Backpressure: in_ready drops when the writeback queue is full or a trap is pending; wb_* held until wb_ready.
//
// Ports: clock/reset (async, active-high); in_valid/in_ready + alu_result/alu_flags/alu_wflags/
//        in_effect/in_tag op input; flags (to ALU); wb_valid/wb_ready/wb_data/wb_tag writeback;
//        trap/trap_ack sticky divide error; skip_count = accepted-but-not-stored ops (wrapping).
module alu_commit
    import alu_commit_pkg::*;
#(
    parameter int                   DEPTH       = 2,
    parameter int                   TAG_WIDTH   = 4,
    parameter logic [TAG_WIDTH-1:0] FLAGS_TAG   = 4'hF,
    parameter logic [15:0]          FLAGS_RESET = 16'h0000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          alu_result,
    input  logic [15:0]          alu_flags,
    input  logic                 alu_wflags,
    input  logic [2:0]           in_effect,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic [15:0]          flags,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [15:0]          wb_data,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic                 trap,
    input  logic                 trap_ack,
    output logic [15:0]          skip_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    flags_t        af;
    effect_t       eff;
    logic          accept;
    logic          dead;
    logic          stored;
    logic          to_flags;
    logic          push;
    logic          trap_set;
    logic [PW:0]   wb_count;
    logic [TAG_WIDTH+15:0] head;
    logic          unused_bits;

    assign af  = flags_t'(alu_flags);
    assign eff = effect_t'(in_effect);

    assign in_ready = (wb_count < FULL_CNT) & ~trap;
    assign accept   = in_valid & in_ready;
    assign dead     = effect_is_dead(eff);

    // A divide error kills the store even when the condition holds.
    assign stored   = accept & store_cond(eff, af.z, af.n) & ~af.de;
    assign to_flags = stored & (in_tag == FLAGS_TAG);
    assign push     = stored & ~to_flags;
    assign trap_set = accept & af.de & ~dead;

    assign unused_bits = ^{af.hi, af.sign, af.mid};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags      <= FLAGS_RESET;
            trap       <= 1'b0;
            skip_count <= 16'h0000;
        end else begin
            // A store aimed at the flags register replaces the whole word and wins
            // over the op's own flag update.
            if (to_flags) begin
                flags <= alu_result;
            end else if (accept & ~dead & alu_wflags) begin
                flags[4:0] <= alu_flags[4:0];
            end

            if (trap_set) begin
                trap <= 1'b1;
            end else if (trap_ack) begin
                trap <= 1'b0;
            end

            if (accept & ~stored) begin
                skip_count <= skip_count + 16'h0001;
            end
        end
    end

    alu_commit_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TAG_WIDTH + 16)
    ) u_wb_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (push),
        .in_data   ({in_tag, alu_result}),
        .out_valid (wb_valid),
        .out_ready (wb_ready),
        .out_data  (head),
        .count     (wb_count)
    );

    assign wb_data = head[15:0];
    assign wb_tag  = head[TAG_WIDTH+15:16];

endmodule

// File: tb/tb_alu_commit.sv
// Randomised + directed bench for alu_commit against a queue-based reference model.
// Latency: n/a.
// Backpressure: wb_ready driven randomly to exercise full/stall cases.
module tb_alu_commit;
    localparam int DEPTH = 2;
    localparam logic [3:0] FTAG = 4'hF;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_result;
    logic [15:0] alu_flags;
    logic        alu_wflags;
    logic [2:0]  in_effect;
    logic [3:0]  in_tag;
    logic [15:0] flags;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [3:0]  wb_tag;
    logic        trap;
    logic        trap_ack;
    logic [15:0] skip_count;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [19:0] mq[$];
    logic [15:0] mflags;
    logic        mtrap;
    logic [15:0] mskip;

    always #5 clock = ~clock;

    alu_commit #(
        .DEPTH(DEPTH), .TAG_WIDTH(4), .FLAGS_TAG(FTAG), .FLAGS_RESET(16'h0000)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_wflags(alu_wflags),
        .in_effect(in_effect), .in_tag(in_tag),
        .flags(flags),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
        .trap(trap), .trap_ack(trap_ack), .skip_count(skip_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, ".wb_valid"}, 32'(wb_valid), 32'(mq.size() != 0));
        check({where, ".wb_data"},  32'(wb_data),  (mq.size() != 0) ? 32'(mq[0][15:0]) : 32'h0);
        check({where, ".wb_tag"},   32'(wb_tag),   (mq.size() != 0) ? 32'(mq[0][19:16]) : 32'h0);
        check({where, ".flags"},    32'(flags),    32'(mflags));
        check({where, ".trap"},     32'(trap),     32'(mtrap));
        check({where, ".skip"},     32'(skip_count), 32'(mskip));
    endtask

    task automatic model_reset();
        mq.delete();
        mflags = 16'h0000;
        mtrap  = 1'b0;
        mskip  = 16'h0000;
    endtask

    // One clock: drive inputs, check in_ready, advance model across the edge, check outputs.
    task automatic cycle(input logic v, input logic [2:0] eff, input logic [15:0] res,
                         input logic [15:0] af, input logic wf, input logic [3:0] tag,
                         input logic wr, input logic ack);
        logic rdy, acc, want, st, kill, de;
        in_valid = v; in_effect = eff; alu_result = res; alu_flags = af;
        alu_wflags = wf; in_tag = tag; wb_ready = wr; trap_ack = ack;
        #1;
        rdy = (mq.size() < DEPTH) && !mtrap;
        check("in_ready", 32'(in_ready), 32'(rdy));
        acc  = v && rdy;
        de   = af[4];
        kill = (eff >= 3'd6);
        case (eff)
            3'd0:    want = af[0];
            3'd1:    want = !af[0];
            3'd2:    want = af[1];
            3'd3:    want = !af[1] && !af[0];
            3'd4:    want = 1'b1;
            default: want = 1'b0;
        endcase
        st = acc && want && !de;
        @(posedge clock);
        if ((mq.size() != 0) && wr) void'(mq.pop_front());
        if (acc && de && !kill) mtrap = 1'b1;
        else if (ack)           mtrap = 1'b0;
        if (st && tag == FTAG)        mflags = res;
        else if (acc && !kill && wf)  mflags[4:0] = af[4:0];
        if (st && tag != FTAG) mq.push_back({tag, res});
        if (acc && !st) mskip = mskip + 16'd1;
        #1;
        check_outputs("cyc");
    endtask

    task automatic idle(input logic wr, input logic ack);
        cycle(1'b0, 3'd6, 16'h0, 16'h0, 1'b0, 4'h0, wr, ack);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        in_valid = 0; alu_result = 0; alu_flags = 0; alu_wflags = 0;
        in_effect = 0; in_tag = 0; wb_ready = 0; trap_ack = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs("reset");
        check("reset.in_ready", 32'(in_ready), 32'h1);
        reset = 1'b0;

        // Unconditional store, then drain it.
        cycle(1, 3'd4, 16'h1234, 16'h0005, 1, 4'h2, 0, 0);
        check("d1.wb_valid", 32'(wb_valid), 32'h1);
        check("d1.wb_data",  32'(wb_data),  32'h1234);
        check("d1.wb_tag",   32'(wb_tag),   32'h2);
        check("d1.flags",    32'(flags),    32'h0005);
        idle(1, 0);

        // Conditional store with false condition, then a dead effect.
        cycle(1, 3'd0, 16'hAAAA, 16'h0006, 1, 4'h3, 1, 0);
        check("d2.skip",  32'(skip_count), 32'h1);
        check("d2.flags", 32'(flags),      32'h0006);
        check("d2.wb_valid", 32'(wb_valid), 32'h0);
        cycle(1, 3'd6, 16'hBBBB, 16'h0009, 1, 4'h3, 1, 0);
        check("d2.flags_kept", 32'(flags), 32'h0006);

        // Fill the queue with a stalled consumer, then drain in order.
        cycle(1, 3'd4, 16'h0011, 16'h0, 0, 4'h1, 0, 0);
        cycle(1, 3'd4, 16'h0022, 16'h0, 0, 4'h2, 0, 0);
        check("d3.full_ready", 32'(in_ready), 32'h0);
        cycle(1, 3'd4, 16'h0033, 16'h0, 0, 4'h3, 0, 0);
        check("d3.head_held", 32'(wb_data), 32'h0011);
        cycle(0, 3'd4, 16'h0, 16'h0, 0, 4'h0, 1, 0);
        check("d3.second", 32'(wb_data), 32'h0022);
        idle(1, 0);
        check("d3.empty", 32'(wb_valid), 32'h0);

        // Store aimed at the flags register.
        cycle(1, 3'd4, 16'h0100, 16'h001F & 16'h000F, 1, FTAG, 1, 0);
        check("d4.flags", 32'(flags), 32'h0100);
        check("d4.wb_valid", 32'(wb_valid), 32'h0);

        // Divide error traps, blocks input, then acknowledged.
        cycle(1, 3'd4, 16'h5555, 16'h0010, 0, 4'h4, 1, 0);
        check("d5.trap", 32'(trap), 32'h1);
        check("d5.in_ready", 32'(in_ready), 32'h0);
        idle(1, 1);
        check("d5.trap_clr", 32'(trap), 32'h0);
        check("d5.ready_back", 32'(in_ready), 32'h1);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] af;
            af = 16'($urandom);
            if ($urandom_range(0, 15) != 0) af[4] = 1'b0;
            cycle(1'($urandom_range(0, 3) != 0), 3'($urandom), 16'($urandom), af,
                  1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        // Walk skip_count to FFFF, then wrap it.
        idle(1, 1);
        idle(1, 1);
        n = 32'(16'hFFFF - mskip);
        in_valid = 1; in_effect = 3'd6; trap_ack = 0; wb_ready = 1;
        repeat (n) @(posedge clock);
        mskip = 16'hFFFF;
        #1;
        check("wrap.preset", 32'(skip_count), 32'hFFFF);
        cycle(1, 3'd5, 16'h0, 16'h0, 0, 4'h0, 1, 0);
        check("wrap.zero", 32'(skip_count), 32'h0);

        // Reset while two entries are queued.
        cycle(1, 3'd4, 16'h0AAA, 16'h0, 0, 4'h1, 0, 0);
        cycle(1, 3'd4, 16'h0BBB, 16'h0, 0, 4'h2, 0, 0);
        check("rst.pre_valid", 32'(wb_valid), 32'h1);
        reset = 1'b1;
        #1;
        model_reset();
        check("rst.wb_valid", 32'(wb_valid), 32'h0);
        check_outputs("rst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
